fmul_pipe: RTL and testbench

- Parameterised, two-stage pipelined floating-point multiplier; generalises the fdiv-internal multiplier.
- Two exponent modes:
  - plain multiply;
  - divide-assist (x2 carries the divisor exponent and a reciprocal mantissa).
- Valid/ready handshake with full-pipeline stall, registered outputs, and overflow/underflow flags.
- Sits between operand issue logic and the FPU result mux. The fdiv datapath instantiates it with MODE_DIV tied high.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fmul_pp_split.sv | 19 +
 rtl/fmul_pipe.sv | 129 ++++++++++++
 tb/tb_fmul_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared float format defaults, derived constants and field helpers
package fpu_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    function automatic int bias_of(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int emax_of(input int ew);
        return (1 << ew) - 1;
    endfunction

    function automatic logic f_sign(input logic [63:0] x, input int ew, input int mw);
        logic [63:0] t;
        t = x >> (ew + mw);
        return t[0];
    endfunction

    function automatic logic [63:0] f_exp(input logic [63:0] x, input int ew, input int mw);
        return (x >> mw) & ((64'd1 << ew) - 64'd1);
    endfunction

    function automatic logic [63:0] f_man(input logic [63:0] x, input int mw);
        return x & ((64'd1 << mw) - 64'd1);
    endfunction

    function automatic logic [63:0] f_zero(input logic s, input int ew, input int mw);
        return 64'(s) << (ew + mw);
    endfunction

    function automatic logic [63:0] f_inf(input logic s, input int ew, input int mw);
        return f_zero(s, ew, mw) | (((64'd1 << ew) - 64'd1) << mw);
    endfunction

endpackage

// File: rtl/fmul_pp_split.sv
// fmul_pp_split: low/high split partial products of two hidden-bit mantissas
module fmul_pp_split
    import fpu_pkg::*;
#(
    parameter int MAN_W = MAN_W_DEF,
    parameter int SPLIT = 17
) (
    input  logic [MAN_W-1:0]         m1_i,
    input  logic [MAN_W-1:0]         m2_i,
    output logic [SPLIT+MAN_W:0]     plo_o,
    output logic [2*MAN_W-SPLIT+1:0] phi_o
);
    localparam int LW = SPLIT + MAN_W + 1;
    localparam int HW = 2 * MAN_W - SPLIT + 2;

    assign plo_o = LW'(m1_i[SPLIT-1:0]) * LW'({1'b1, m2_i});
    assign phi_o = HW'({1'b1, m1_i[MAN_W-1:SPLIT]}) * HW'({1'b1, m2_i});

endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: two-stage pipelined float multiplier with a divide-assist exponent mode
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int SPLIT = 17
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode_div,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic                   ovf,
    output logic                   unf
);
    localparam int FW   = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int LW   = SPLIT + MAN_W + 1;
    localparam int HW   = 2 * MAN_W - SPLIT + 2;
    localparam int XW   = EXP_W + 2;
    localparam int BIAS = bias_of(EXP_W);
    localparam int EMAX = emax_of(EXP_W);

    logic                 adv;
    logic [63:0]          x1w, x2w;
    logic [EXP_W-1:0]     e1, e2;
    logic [MAN_W-1:0]     m1, m2;
    logic signed [XW-1:0] e1x, e2x;
    logic                 s1_v_q, sy_q, zin_q, iin_q;
    logic                 sy_d, zin_d, iin_d;
    logic [LW-1:0]        plo_d, plo_q;
    logic [HW-1:0]        phi_d, phi_q;
    logic signed [XW-1:0] eb_d, eb_q, ef;
    logic [PW-1:0]        p;
    logic [MAN_W-1:0]     mf;
    logic                 zr, ir;
    logic                 out_v_q, ovf_q, unf_q, ovf_d, unf_d;
    logic [FW-1:0]        y_q, y_d;

    assign adv      = !out_v_q || out_ready;
    assign in_ready = adv;

    assign x1w = 64'(x1);
    assign x2w = 64'(x2);
    assign e1  = EXP_W'(f_exp(x1w, EXP_W, MAN_W));
    assign e2  = EXP_W'(f_exp(x2w, EXP_W, MAN_W));
    assign m1  = MAN_W'(f_man(x1w, MAN_W));
    assign m2  = MAN_W'(f_man(x2w, MAN_W));
    assign e1x = $signed(XW'(e1));
    assign e2x = $signed(XW'(e2));

    fmul_pp_split #(.MAN_W(MAN_W), .SPLIT(SPLIT)) u_pp (
        .m1_i  (m1),
        .m2_i  (m2),
        .plo_o (plo_d),
        .phi_o (phi_d)
    );

    // S1 next state: result sign, exponent base for the selected mode, special-input flags
    always_comb begin
        sy_d  = f_sign(x1w, EXP_W, MAN_W) ^ f_sign(x2w, EXP_W, MAN_W);
        eb_d  = mode_div ? e1x - e2x + XW'(BIAS - 1) : e1x + e2x - XW'(BIAS);
        zin_d = (e1 == '0) || (e2 == '0);
        iin_d = (e1 == '1) || (e2 == '1);
    end

    // S1 register: captures operands whenever the whole pipe advances
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v_q <= 1'b0;
            sy_q   <= 1'b0;
            plo_q  <= '0;
            phi_q  <= '0;
            eb_q   <= '0;
            zin_q  <= 1'b0;
            iin_q  <= 1'b0;
        end else if (adv) begin
            s1_v_q <= in_valid;
            sy_q   <= sy_d;
            plo_q  <= plo_d;
            phi_q  <= phi_d;
            eb_q   <= eb_d;
            zin_q  <= zin_d;
            iin_q  <= iin_d;
        end
    end

    assign p  = PW'(plo_q) + (PW'(phi_q) << SPLIT);
    assign ef = p[PW-1] ? eb_q + XW'(1) : eb_q;
    assign mf = MAN_W'(p[PW-1] ? p >> (MAN_W + 1) : p >> MAN_W);

    // S2 next state: zero forcing beats infinity forcing, which beats the normal result
    always_comb begin
        zr    = zin_q || (ef <= XW'(0));
        ir    = iin_q || (ef >= XW'(EMAX));
        y_d   = zr ? FW'(f_zero(sy_q, EXP_W, MAN_W))
              : ir ? FW'(f_inf(sy_q, EXP_W, MAN_W))
              : {sy_q, ef[EXP_W-1:0], mf};
        unf_d = zr;
        ovf_d = !zr && ir;
    end

    // S2 register: result and flags, held stable while downstream stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_v_q <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (adv) begin
            out_v_q <= s1_v_q;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign out_valid = out_v_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: scoreboard bench for fmul_pipe with a float-arithmetic reference model
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode_div = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic        ovf;
    logic        unf;

    int chk_n = 0;
    int pass_n = 0;

    fmul_pipe #(.EXP_W(8), .MAN_W(23), .SPLIT(17)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode_div  (mode_div),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_n, chk_n);
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        chk_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endfunction

    // Reference: returns {ovf, unf, y} from real-valued float rules (full 48-bit product)
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic md);
        int          e1, e2, eb, ef;
        logic [63:0] pr;
        logic [22:0] mt;
        logic        sy;
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        sy = a[31] ^ b[31];
        pr = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
        eb = md ? e1 - e2 + 126 : e1 + e2 - 127;
        if (pr[47]) begin
            ef = eb + 1;
            mt = pr[46:24];
        end else begin
            ef = eb;
            mt = pr[45:23];
        end
        if (e1 == 0 || e2 == 0 || ef <= 0) return {2'b01, sy, 31'd0};
        if (e1 == 255 || e2 == 255 || ef >= 255) return {2'b10, sy, 8'hFF, 23'd0};
        return {2'b00, sy, 8'(ef), mt};
    endfunction

    function automatic logic [31:0] rnd_f();
        int         s;
        logic [7:0] e;
        s = $urandom_range(0, 9);
        e = (s == 0) ? 8'd0 : (s == 1) ? 8'hFF :
            (s < 6) ? 8'($urandom_range(100, 155)) : 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    typedef struct {
        logic [33:0] r;
        int          acc;
        int          st;
    } ent_t;

    ent_t        sb[$];
    ent_t        hd;
    int          cyc_n = 0;
    int          stall_n = 0;
    logic        stalled = 1'b0;
    logic [33:0] held;

    // Compare process: all handshakes are evaluated mid-cycle, ahead of the edge that commits them
    always @(negedge clk) begin
        if (!rstn) begin
            stalled = 1'b0;
        end else begin
            cyc_n++;
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (stalled && out_valid) chk("hold", 64'({ovf, unf, y}), 64'(held));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk_n++;
                    $display("FAIL spurious: output y=%h with nothing expected", y);
                end else begin
                    hd = sb.pop_front();
                    chk("result", 64'({ovf, unf, y}), 64'(hd.r));
                    chk("latency", 64'(cyc_n), 64'(hd.acc + 2 + stall_n - hd.st));
                end
            end
            if (in_valid && in_ready) sb.push_back('{model(x1, x2, mode_div), cyc_n, stall_n});
            stalled = out_valid && !out_ready;
            if (stalled) stall_n++;
            held = {ovf, unf, y};
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic md);
        logic ok;
        int   t;
        in_valid = 1'b1;
        x1 = a;
        x2 = b;
        mode_div = md;
        t = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 50);
        if (!ok) begin
            chk_n++;
            $display("FAIL send: operands %h %h not accepted within 50 cycles", a, b);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_y", 64'({ovf, unf, y}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        chk("pin_mul", 64'(model(32'h3FC00000, 32'h40000000, 1'b0)), 64'h0_40400000);
        chk("pin_carry", 64'(model(32'h3FC00000, 32'h3FC00000, 1'b0)), 64'h0_40100000);
        chk("pin_neg", 64'(model(32'hBF800000, 32'h40400000, 1'b0)), 64'h0_C0400000);
        chk("pin_div1", 64'(model(32'h40400000, 32'h3F800000, 1'b1)), 64'h0_3FC00000);
        chk("pin_div2", 64'(model(32'h40000000, 32'h40000000, 1'b1)), 64'h0_3F000000);
        chk("pin_ovf", 64'(model(32'h7F000000, 32'h40000000, 1'b0)), 64'h2_7F800000);
        chk("pin_unf", 64'(model(32'h00800000, 32'h3F000000, 1'b0)), 64'h1_00000000);
        chk("pin_unf_neg", 64'(model(32'h80800000, 32'h3F000000, 1'b0)), 64'h1_80000000);
        chk("pin_zero_inf", 64'(model(32'h00000000, 32'h7F800000, 1'b0)), 64'h1_00000000);

        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        send(32'h3FC00000, 32'h40000000, 1'b0);
        send(32'h3FC00000, 32'h3FC00000, 1'b0);
        send(32'hBF800000, 32'h40400000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b1);
        send(32'h40000000, 32'h40000000, 1'b1);
        send(32'h7F000000, 32'h40000000, 1'b0);
        send(32'h7F800000, 32'h3F800000, 1'b0);
        send(32'h3F800000, 32'h7FFFFFFF, 1'b1);
        send(32'h00800000, 32'h3F000000, 1'b0);
        send(32'h80800000, 32'h3F000000, 1'b0);
        send(32'h00000000, 32'h7F800000, 1'b0);
        idle(4);

        fork
            begin
                send(32'h3F800000, 32'h40000000, 1'b0);
                send(32'h40400000, 32'h40400000, 1'b0);
                send(32'h41000000, 32'h40000000, 1'b1);
                send(32'hC0A00000, 32'h3FC00000, 1'b0);
                send(32'h3F000000, 32'h3E800000, 1'b1);
                send(32'h42C80000, 32'hC2C80000, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        idle(4);

        send(32'h3FC00000, 32'h40000000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b1);
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #2 rstn = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_y", 64'({ovf, unf, y}), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        send(32'hBF800000, 32'h40400000, 1'b0);
        idle(4);

        for (int i = 0; i < 2000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            x1        = rnd_f();
            x2        = rnd_f();
            mode_div  = 1'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("drain", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
